// File: rtl/qupls4_copro_engine.sv
// Coprocessor execution engine: fetch/decode/execute over a private register file with a
// req/ack memory port, a wait/wakeup handshake and a sticky fault on illegal opcodes.
module qupls4_copro_engine #(
   parameter int unsigned DW   = 64,
   parameter int unsigned NREG = 16,
   parameter int unsigned IAW  = 10,
   parameter int unsigned MAW  = 32,
   parameter int unsigned IMMW = 15,
   localparam int unsigned RW  = $clog2(NREG),
   localparam int unsigned IW  = IMMW + 3 * RW + 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           wake,
   output logic [IAW-1:0] imem_adr,
   input  logic [IW-1:0]  imem_dat,
   output logic           mem_req,
   output logic           mem_we,
   output logic [MAW-1:0] mem_adr,
   output logic [DW-1:0]  mem_wdat,
   input  logic           mem_ack,
   input  logic [DW-1:0]  mem_rdat,
   output logic           busy,
   output logic           waiting,
   output logic           fault
);

   localparam int unsigned SHW = $clog2(DW);

   localparam logic [4:0] OpNop    = 5'd0;
   localparam logic [4:0] OpMove   = 5'd1;
   localparam logic [4:0] OpAdd    = 5'd2;
   localparam logic [4:0] OpAnd    = 5'd3;
   localparam logic [4:0] OpOr     = 5'd4;
   localparam logic [4:0] OpXor    = 5'd5;
   localparam logic [4:0] OpShl    = 5'd6;
   localparam logic [4:0] OpShr    = 5'd7;
   localparam logic [4:0] OpSkip   = 5'd8;
   localparam logic [4:0] OpJmp    = 5'd9;
   localparam logic [4:0] OpJcc    = 5'd10;
   localparam logic [4:0] OpLoad   = 5'd11;
   localparam logic [4:0] OpStore  = 5'd13;
   localparam logic [4:0] OpStorei = 5'd14;
   localparam logic [4:0] OpWait   = 5'd15;

   localparam logic [3:0] CcEq = 4'd0, CcNe = 4'd1, CcLt = 4'd2, CcLe = 4'd3;
   localparam logic [3:0] CcGe = 4'd4, CcGt = 4'd5, CcDjne = 4'd6;

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWait, StHalt} state_e;

   state_e          state_q, state_d;
   logic [IAW-1:0]  ip_q, ip_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [DW-1:0]   regs_q [NREG];
   logic [DW-1:0]   regs_d [NREG];
   logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [MAW-1:0]  mem_adr_q, mem_adr_d;
   logic [DW-1:0]   mem_wdat_q, mem_wdat_d;
   logic            fault_q, fault_d, wake_q, wake_d;

   logic [4:0]      op_f;
   logic [RW-1:0]   rd_f, rs1_f, rs2_f;
   logic [IMMW-1:0] imm_f;
   logic [3:0]      cond;
   logic [DW-1:0]   opa, rb, imm_x, opb, dec;
   logic [IAW-1:0]  ip_inc;
   logic            wr_en, taken;
   logic [RW-1:0]   wr_idx;
   logic [DW-1:0]   wr_dat;

   assign op_f   = ir_q[4:0];
   assign rd_f   = ir_q[5 +: RW];
   assign rs1_f  = ir_q[5 + RW +: RW];
   assign rs2_f  = ir_q[5 + 2 * RW +: RW];
   assign imm_f  = ir_q[5 + 3 * RW +: IMMW];
   assign cond   = 4'(rd_f);
   // R0 is never written, so it reads back as zero without a read-side mux
   assign opa    = regs_q[rs1_f];
   assign rb     = regs_q[rs2_f];
   assign imm_x  = {{(DW - IMMW){imm_f[IMMW-1]}}, imm_f};
   assign opb    = rb + imm_x;
   assign dec    = opa - DW'(1);
   assign ip_inc = ip_q + IAW'(1);

   always_comb begin
      state_d    = state_q;
      ip_d       = ip_q;
      ir_d       = ir_q;
      regs_d     = regs_q;
      mem_req_d  = mem_req_q;
      mem_we_d   = mem_we_q;
      mem_adr_d  = mem_adr_q;
      mem_wdat_d = mem_wdat_q;
      fault_d    = fault_q;
      wake_d     = wake_q | wake;
      wr_en      = 1'b0;
      wr_idx     = rd_f;
      wr_dat     = '0;
      taken      = 1'b0;
      unique case (state_q)
         StFetch:  if (en && !fault_q) state_d = StDecode;
         StDecode: begin
            ir_d    = imem_dat;
            state_d = StExec;
         end
         StExec: begin
            state_d = StFetch;
            ip_d    = ip_inc;
            case (op_f)
               OpNop:  ;
               OpMove: begin wr_en = 1'b1; wr_dat = opa; end
               OpAdd:  begin wr_en = 1'b1; wr_dat = opa + opb; end
               OpAnd:  begin wr_en = 1'b1; wr_dat = opa & opb; end
               OpOr:   begin wr_en = 1'b1; wr_dat = opa | opb; end
               OpXor:  begin wr_en = 1'b1; wr_dat = opa ^ opb; end
               OpShl:  begin wr_en = 1'b1; wr_dat = opa << opb[SHW-1:0]; end
               OpShr:  begin wr_en = 1'b1; wr_dat = opa >> opb[SHW-1:0]; end
               OpSkip: if (opa != '0) ip_d = ip_q + IAW'(2);
               OpJmp:  ip_d = IAW'(imm_f);
               OpJcc: begin
                  case (cond)
                     CcEq: taken = (opa == rb);
                     CcNe: taken = (opa != rb);
                     CcLt: taken = ($signed(opa) <  $signed(rb));
                     CcLe: taken = ($signed(opa) <= $signed(rb));
                     CcGe: taken = ($signed(opa) >= $signed(rb));
                     CcGt: taken = ($signed(opa) >  $signed(rb));
                     CcDjne: begin
                        wr_en  = 1'b1;
                        wr_idx = rs1_f;
                        wr_dat = dec;
                        taken  = (dec != '0);
                     end
                     default: begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                        ip_d    = ip_q;
                     end
                  endcase
                  if (taken) ip_d = IAW'(imm_f);
               end
               OpLoad, OpStore, OpStorei: begin
                  mem_req_d = 1'b1;
                  mem_we_d  = (op_f != OpLoad);
                  mem_adr_d = MAW'(opa + imm_x);
                  if (op_f == OpStore) mem_wdat_d = rb;
                  if (op_f == OpStorei) begin
                     mem_adr_d  = MAW'(opa);
                     mem_wdat_d = imm_x;
                  end
                  state_d = StMem;
                  ip_d    = ip_q;
               end
               OpWait: begin
                  if (wake_q) begin
                     wake_d = wake;
                  end else begin
                     state_d = StWait;
                     ip_d    = ip_q;
                  end
               end
               default: begin
                  fault_d = 1'b1;
                  state_d = StHalt;
                  ip_d    = ip_q;
               end
            endcase
         end
         StMem: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               ip_d      = ip_inc;
               state_d   = StFetch;
               if (!mem_we_q) begin
                  wr_en  = 1'b1;
                  wr_dat = mem_rdat;
               end
            end
         end
         StWait: begin
            if (wake_q) begin
               wake_d  = wake;
               ip_d    = ip_inc;
               state_d = StFetch;
            end
         end
         StHalt:  ;
         default: state_d = StHalt;
      endcase
      if (wr_en && (wr_idx != '0)) regs_d[wr_idx] = wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StFetch;
         ip_q       <= '0;
         ir_q       <= '0;
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_adr_q  <= '0;
         mem_wdat_q <= '0;
         fault_q    <= 1'b0;
         wake_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ip_q       <= ip_d;
         ir_q       <= ir_d;
         regs_q     <= regs_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         mem_adr_q  <= mem_adr_d;
         mem_wdat_q <= mem_wdat_d;
         fault_q    <= fault_d;
         wake_q     <= wake_d;
      end
   end

   assign imem_adr = ip_q;
   assign mem_req  = mem_req_q;
   assign mem_we   = mem_we_q;
   assign mem_adr  = mem_adr_q;
   assign mem_wdat = mem_wdat_q;
   assign busy     = (state_q != StFetch);
   assign waiting  = (state_q == StWait);
   assign fault    = fault_q;

endmodule

// File: tb/tb_qupls4_copro_engine.sv
// Directed bench for qupls4_copro_engine: ROM program plus a scoreboard of expected memory
// transactions that a bench-side memory responder pops and compares.
module tb_qupls4_copro_engine;

   localparam int OpNop = 0, OpMove = 1, OpAdd = 2, OpAnd = 3, OpOr = 4, OpXor = 5;
   localparam int OpShl = 6, OpShr = 7, OpSkip = 8, OpJcc = 10, OpLoad = 11;
   localparam int OpCalcIndex = 12, OpStore = 13, OpStorei = 14, OpWait = 15;
   localparam int CcLt = 2, CcDjne = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        wake = 1'b0;
   logic [9:0]  imem_adr;
   logic [31:0] imem_dat;
   logic        mem_req, mem_we, mem_ack = 1'b0;
   logic [31:0] mem_adr;
   logic [63:0] mem_wdat;
   logic [63:0] mem_rdat = '0;
   logic        busy, waiting, fault;

   qupls4_copro_engine dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wake(wake),
      .imem_adr(imem_adr), .imem_dat(imem_dat),
      .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
      .mem_ack(mem_ack), .mem_rdat(mem_rdat),
      .busy(busy), .waiting(waiting), .fault(fault)
   );

   always #5 clk = ~clk;

   logic [31:0] rom [1024];
   always @(posedge clk) imem_dat <= rom[imem_adr];

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [63:0] wdat;
      logic        chkw;
   } txn_t;
   txn_t sb[$];

   int          checks = 0;
   int          errors = 0;
   int          w;
   logic [31:0] last_adr;

   function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                       input int rs2, input int imm);
      return {imm[14:0], rs2[3:0], rs1[3:0], rd[3:0], op[4:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic prog(input int a, input int op, input int rd, input int rs1,
                       input int rs2, input int imm);
      rom[a] = enc(op, rd, rs1, rs2, imm);
   endtask

   task automatic expect_txn(input logic [31:0] adr, input logic we, input logic [63:0] wdat,
                             input logic chkw);
      txn_t t;
      t.adr = adr; t.we = we; t.wdat = wdat; t.chkw = chkw;
      sb.push_back(t);
   endtask

   // Wait (bounded) for a request, then pop and compare it against the scoreboard.
   task automatic wait_req(input string tag, output int waited);
      txn_t t;
      waited = 0;
      while (mem_req !== 1'b1 && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, "_req"}, 64'(mem_req), 64'd1);
      if (mem_req === 1'b1) begin
         checks++;
         assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=pending", tag);
         end
         if (sb.size() > 0) begin
            t = sb.pop_front();
            last_adr = t.adr;
            chk({tag, "_adr"}, 64'(mem_adr), 64'(t.adr));
            chk({tag, "_we"}, 64'(mem_we), 64'(t.we));
            if (t.chkw) chk({tag, "_wdat"}, mem_wdat, t.wdat);
         end
      end
   endtask

   task automatic finish_ack(input string tag, input int delay, input logic [63:0] rdat);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk({tag, "_hold_req"}, 64'(mem_req), 64'd1);
         chk({tag, "_hold_adr"}, 64'(mem_adr), 64'(last_adr));
      end
      mem_ack  = 1'b1;
      mem_rdat = rdat;
      @(negedge clk);
      mem_ack  = 1'b0;
      mem_rdat = '0;
      chk({tag, "_req_drop"}, 64'(mem_req), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = enc(OpNop, 0, 0, 0, 0);
      // ALU chain and result stores
      prog(0, OpAdd, 1, 0, 0, 5);
      prog(1, OpShl, 2, 1, 0, 3);
      prog(2, OpXor, 3, 2, 1, 0);
      prog(3, OpStore, 0, 0, 3, 'h10);     expect_txn('h10, 1, 45, 1);
      prog(4, OpStore, 0, 0, 2, 'h11);     expect_txn('h11, 1, 40, 1);
      // DJNE countdown loop
      prog(5, OpAdd, 1, 0, 0, 4);
      prog(6, OpJcc, CcDjne, 1, 0, 6);
      prog(7, OpStore, 0, 0, 1, 'h12);     expect_txn('h12, 1, 0, 1);
      // slow store, load back, STOREI
      prog(8, OpAdd, 1, 0, 0, 'h100);
      prog(9, OpStore, 0, 1, 2, 8);        expect_txn('h108, 1, 40, 1);
      prog(10, OpLoad, 5, 1, 0, 8);        expect_txn('h108, 0, 0, 0);
      prog(11, OpStore, 0, 0, 5, 'h13);    expect_txn('h13, 1, 64'hDEAD, 1);
      prog(12, OpStorei, 0, 1, 0, -2);     expect_txn('h100, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
      // remaining ALU ops and a signed branch over wrong-path stores
      prog(13, OpOr, 6, 3, 0, 'h100);
      prog(14, OpShr, 7, 6, 0, 4);
      prog(15, OpAnd, 8, 6, 0, 'hF0);
      prog(16, OpMove, 9, 7, 0, 0);
      prog(17, OpAdd, 10, 0, 0, -1);
      prog(18, OpJcc, CcLt, 10, 1, 21);
      prog(19, OpStore, 0, 0, 0, 'h7F);
      prog(20, OpStore, 0, 0, 0, 'h7F);
      prog(21, OpStore, 0, 0, 6, 'h20);    expect_txn('h20, 1, 'h12D, 1);
      prog(22, OpStore, 0, 0, 7, 'h21);    expect_txn('h21, 1, 'h12, 1);
      prog(23, OpStore, 0, 0, 8, 'h22);    expect_txn('h22, 1, 'h20, 1);
      prog(24, OpStore, 0, 0, 9, 'h23);    expect_txn('h23, 1, 'h12, 1);
      prog(25, OpAdd, 0, 0, 0, 7);
      prog(26, OpStore, 0, 0, 0, 'h24);    expect_txn('h24, 1, 0, 1);
      prog(27, OpSkip, 0, 1, 0, 0);
      prog(28, OpStore, 0, 0, 0, 'h7F);
      // wake before first WAIT, none before the second
      prog(32, OpWait, 0, 0, 0, 0);
      prog(33, OpWait, 0, 0, 0, 0);
      prog(34, OpStore, 0, 0, 1, 'h25);    expect_txn('h25, 1, 'h100, 1);
      prog(35, OpCalcIndex, 0, 0, 0, 0);

      #1;
      chk("rst_imem_adr", 64'(imem_adr), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_adr", 64'(mem_adr), 64'd0);
      chk("rst_mem_wdat", mem_wdat, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_waiting", 64'(waiting), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("en_low_adr", 64'(imem_adr), 64'd0);
      chk("en_low_busy", 64'(busy), 64'd0);

      en = 1'b1;
      repeat (8) @(negedge clk);
      chk("t1_exec2_adr", 64'(imem_adr), 64'd2);
      chk("t1_exec2_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("t1_fetch3_adr", 64'(imem_adr), 64'd3);
      chk("t1_fetch3_busy", 64'(busy), 64'd0);
      wait_req("st_r3", w);   chk("st_r3_lat", 64'(w), 64'd3);  finish_ack("st_r3", 0, '0);
      wait_req("st_r2", w);   chk("st_r2_lat", 64'(w), 64'd3);  finish_ack("st_r2", 0, '0);

      wait_req("djne", w);    chk("djne_lat", 64'(w), 64'd18); finish_ack("djne", 0, '0);

      wait_req("st_108", w);  chk("st_108_lat", 64'(w), 64'd6); finish_ack("st_108", 4, '0);
      wait_req("ld_108", w);  chk("ld_108_lat", 64'(w), 64'd3);
      finish_ack("ld_108", 0, 64'hDEAD);
      wait_req("st_dead", w); finish_ack("st_dead", 0, '0);
      wait_req("storei", w);  finish_ack("storei", 0, '0);

      wait_req("st_r6", w);   chk("jlt_lat", 64'(w), 64'd21);  finish_ack("st_r6", 0, '0);
      wait_req("st_r7", w);   finish_ack("st_r7", 0, '0);
      wait_req("st_r8", w);   finish_ack("st_r8", 0, '0);
      wait_req("st_r9", w);   finish_ack("st_r9", 0, '0);
      wait_req("st_r0", w);   chk("st_r0_lat", 64'(w), 64'd6); finish_ack("st_r0", 0, '0);

      wake = 1'b1;
      @(negedge clk);
      wake = 1'b0;
      w = 0;
      while (waiting !== 1'b1 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("wait1_lat", 64'(w), 64'd17);
      chk("wait2_adr", 64'(imem_adr), 64'd33);
      repeat (5) @(negedge clk);
      chk("wait2_parked", 64'(waiting), 64'd1);
      chk("wait2_parked_busy", 64'(busy), 64'd1);
      wake = 1'b1;
      @(negedge clk);
      wake = 1'b0;
      chk("wake_flag_cycle", 64'(waiting), 64'd1);
      @(negedge clk);
      chk("wake_resume", 64'(waiting), 64'd0);
      chk("wake_resume_adr", 64'(imem_adr), 64'd34);
      wait_req("st_25", w);   chk("st_25_lat", 64'(w), 64'd3);  finish_ack("st_25", 0, '0);

      w = 0;
      while (fault !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("fault_lat", 64'(w), 64'd3);
      chk("fault_busy", 64'(busy), 64'd1);
      repeat (10) @(negedge clk);
      chk("halt_adr", 64'(imem_adr), 64'd35);
      chk("halt_fault", 64'(fault), 64'd1);
      chk("halt_req", 64'(mem_req), 64'd0);

      rst_n = 1'b0;
      #1;
      chk("rst2_fault", 64'(fault), 64'd0);
      chk("rst2_busy", 64'(busy), 64'd0);
      prog(0, OpAdd, 5, 0, 0, 'h55);
      prog(1, OpStore, 0, 0, 5, 'h30);     expect_txn('h30, 1, 'h55, 1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_req("st_30", w);   chk("st_30_lat", 64'(w), 64'd6);
      repeat (2) @(negedge clk);
      chk("st_30_pending", 64'(mem_req), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midop_req", 64'(mem_req), 64'd0);
      chk("midop_adr", 64'(imem_adr), 64'd0);
      chk("midop_mem_adr", 64'(mem_adr), 64'd0);
      chk("midop_wdat", mem_wdat, 64'd0);
      chk("midop_busy", 64'(busy), 64'd0);
      prog(0, OpStore, 0, 0, 5, 'h31);     expect_txn('h31, 1, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      wait_req("st_31", w);   chk("st_31_lat", 64'(w), 64'd3);  finish_ack("st_31", 0, '0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
